// File: rtl/mcs4_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mcs4_bus_master
// Brief    : MCS-4 bus sequencer issuing ROM fetches and (with MCS4_IOWR_EN
//            defined) SRC/WRR two-cycle port writes over the 4-bit bus.
// Revision : 1.0 - initial release
// ============================================================================
module mcs4_bus_master #(
  parameter logic [1:0] SAMPLE_TICK = 2'd3
) (
  input  logic        sysclk,
  input  logic        poc_n,
  output logic        clk1_pad,
  output logic        clk2_pad,
  output logic        sync_pad,
  output logic        poc_pad,
  output logic        cmrom_pad,
  input  logic [3:0]  data_in,
  output logic [3:0]  data_out,
  output logic        data_dir,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [11:0] cmd_addr,
  input  logic [3:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data
);

  localparam logic [2:0] c_SUB_A1 = 3'd0;
  localparam logic [2:0] c_SUB_A2 = 3'd1;
  localparam logic [2:0] c_SUB_A3 = 3'd2;
  localparam logic [2:0] c_SUB_M1 = 3'd3;
  localparam logic [2:0] c_SUB_M2 = 3'd4;
  localparam logic [2:0] c_SUB_X1 = 3'd5;
  localparam logic [2:0] c_SUB_X2 = 3'd6;
  localparam logic [2:0] c_SUB_X3 = 3'd7;

  localparam logic [1:0] c_ST_NOP   = 2'd0;
  localparam logic [1:0] c_ST_FETCH = 2'd1;
`ifdef MCS4_IOWR_EN
  localparam logic [1:0] c_ST_SRC   = 2'd2;
  localparam logic [1:0] c_ST_WRR   = 2'd3;
`endif

  logic        r_run;
  logic        r_poc;
  logic [4:0]  r_phase;
  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [11:0] r_addr;
  logic [3:0]  r_rsp_hi;
  logic [7:0]  r_rsp_data;
  logic [2:0]  w_sub;
  logic [1:0]  w_tick;
  logic        w_cycle_end;
  logic        w_pending;
  logic        w_ready;
  logic        w_accept;

  assign w_sub       = r_phase[4:2];
  assign w_tick      = r_phase[1:0];
  assign w_cycle_end = r_run & (w_sub == c_SUB_X3) & (w_tick == 2'd3);

`ifdef MCS4_IOWR_EN
  logic [3:0] r_wdata;
  assign w_pending = (r_state == c_ST_SRC);
`else
  logic w_unused_cmd;
  assign w_unused_cmd = ^{cmd_op, cmd_wdata};
  assign w_pending    = 1'b0;
`endif

  assign w_ready   = w_cycle_end & ~r_poc & ~w_pending;
  assign w_accept  = w_ready & cmd_valid;
  assign cmd_ready = w_ready;
  assign poc_pad   = r_poc;
  assign rsp_data  = r_rsp_data;

  // r_run holds the phase at A1 tick 0 for one edge after release so that
  // tick is actually presented on the pads.
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      r_run   <= 1'b0;
      r_poc   <= 1'b1;
      r_phase <= 5'd0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        r_phase <= r_phase + 5'd1;
      end
      if (w_cycle_end) begin
        r_poc <= 1'b0;
      end
    end
  end

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      r_state <= c_ST_NOP;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      r_addr <= 12'd0;
`ifdef MCS4_IOWR_EN
      r_wdata <= 4'd0;
`endif
    end else if (w_accept) begin
      r_addr <= cmd_addr;
`ifdef MCS4_IOWR_EN
      r_wdata <= cmd_wdata;
`endif
    end
  end

  // High nibble is staged so rsp_data only changes once the byte is whole.
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      r_rsp_hi   <= 4'd0;
      r_rsp_data <= 8'd0;
    end else if ((r_state == c_ST_FETCH) && (w_tick == SAMPLE_TICK)) begin
      if (w_sub == c_SUB_M1) begin
        r_rsp_hi <= data_in;
      end
      if (w_sub == c_SUB_M2) begin
        r_rsp_data <= {r_rsp_hi, data_in};
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (w_cycle_end) begin
`ifdef MCS4_IOWR_EN
      if (r_state == c_ST_SRC) begin
        w_next_state = c_ST_WRR;
      end else if (w_accept) begin
        w_next_state = cmd_op ? c_ST_SRC : c_ST_FETCH;
      end else begin
        w_next_state = c_ST_NOP;
      end
`else
      w_next_state = w_accept ? c_ST_FETCH : c_ST_NOP;
`endif
    end
  end

  always_comb begin
    clk1_pad  = r_run & (w_tick == 2'd0);
    clk2_pad  = r_run & (w_tick == 2'd2);
    sync_pad  = r_run & (w_sub == c_SUB_X3);
    cmrom_pad = 1'b0;
    data_dir  = 1'b0;
    data_out  = 4'd0;
    rsp_valid = 1'b0;
    if ((r_state != c_ST_NOP) && (w_sub <= c_SUB_A3)) begin
      data_dir = 1'b1;
      case (w_sub)
        c_SUB_A1: data_out = r_addr[3:0];
        c_SUB_A2: data_out = r_addr[7:4];
        default:  data_out = r_addr[11:8];
      endcase
    end
    case (r_state)
      c_ST_FETCH: begin
        cmrom_pad = (w_sub == c_SUB_A3);
        rsp_valid = (w_sub == c_SUB_X1) && (w_tick == 2'd0);
      end
`ifdef MCS4_IOWR_EN
      c_ST_SRC: begin
        if (w_sub == c_SUB_X2) begin
          data_dir  = 1'b1;
          data_out  = r_addr[11:8];
          cmrom_pad = 1'b1;
        end
      end
      c_ST_WRR: begin
        if (w_sub == c_SUB_M2) begin
          data_dir  = 1'b1;
          data_out  = 4'b0010;
          cmrom_pad = 1'b1;
        end else if (w_sub == c_SUB_X2) begin
          data_dir = 1'b1;
          data_out = r_wdata;
        end
      end
`endif
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mcs4_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for mcs4_bus_master: directed and random cycles against a tick-level
// model of the bus sequence; port-write steps build only with MCS4_IOWR_EN.
module tb_mcs4_bus_master;

  localparam int c_NOP   = 0;
  localparam int c_FETCH = 1;
  localparam int c_SRC   = 2;
  localparam int c_WRR   = 3;

  logic        sysclk = 1'b0;
  logic        poc_n  = 1'b1;
  logic        clk1_pad, clk2_pad, sync_pad, poc_pad, cmrom_pad;
  logic [3:0]  data_in = 4'd0;
  logic [3:0]  data_out;
  logic        data_dir;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [11:0] cmd_addr = 12'd0;
  logic [3:0]  cmd_wdata = 4'd0;
  logic        rsp_valid;
  logic [7:0]  rsp_data;

  always #5 sysclk = ~sysclk;

  mcs4_bus_master dut (
    .sysclk    (sysclk),
    .poc_n     (poc_n),
    .clk1_pad  (clk1_pad),
    .clk2_pad  (clk2_pad),
    .sync_pad  (sync_pad),
    .poc_pad   (poc_pad),
    .cmrom_pad (cmrom_pad),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_dir  (data_dir),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  logic [11:0] obs;
  assign obs = {poc_pad, clk1_pad, clk2_pad, sync_pad, cmrom_pad, data_dir,
                data_out, rsp_valid, cmd_ready};

  int          errors = 0;
  int          checks = 0;
  int          rv_count = 0;
  int          cur_kind;
  logic [11:0] cur_addr;
  logic [3:0]  cur_wd;
  bit          poc_exp;
  logic [7:0]  exp_rsp;
  logic [7:0]  rom [0:4095];
  logic [3:0]  io_chip = 4'd0;
  logic [3:0]  io_out = 4'd0;
  bit          wrr_seen;
  int          rv0;

  always @(posedge sysclk) if (rsp_valid === 1'b1) rv_count <= rv_count + 1;

  task automatic chk(input string tag, input int t, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, o, e);
    end
  endtask

  // Expected pads for tick t of an instruction cycle of the given kind.
  function automatic logic [11:0] model(int t, int kind, logic [11:0] a, logic [3:0] w, bit poc);
    int sub = t / 4;
    int tk  = t % 4;
    logic cm = 1'b0, dir = 1'b0, rv = 1'b0, rdy;
    logic [3:0] d = 4'd0;
    rdy = (sub == 7) && (tk == 3) && !poc && (kind != c_SRC);
    if (kind != c_NOP && sub < 3) begin
      dir = 1'b1;
      d   = a[sub*4 +: 4];
      cm  = (kind == c_FETCH) && (sub == 2);
    end
    if (kind == c_FETCH && sub == 5 && tk == 0) rv = 1'b1;
    if (kind == c_SRC && sub == 6) begin dir = 1'b1; d = a[11:8]; cm = 1'b1; end
    if (kind == c_WRR && sub == 4) begin dir = 1'b1; d = 4'h2;    cm = 1'b1; end
    if (kind == c_WRR && sub == 6) begin dir = 1'b1; d = w; end
    return {poc, tk == 0, tk == 2, sub == 7, cm, dir, d, rv, rdy};
  endfunction

  task automatic do_reset();
    poc_n     = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("reset_pads", 0, {4'h0, obs}, 16'h0800);
    chk("reset_rsp", 0, {8'h0, rsp_data}, 16'h0000);
    repeat (3) @(posedge sysclk);
    #1;
    chk("reset_hold", 0, {4'h0, obs}, 16'h0800);
    @(negedge sysclk);
    poc_n = 1'b1;
    @(posedge sysclk);
    #1;
    cur_kind = c_NOP;
    poc_exp  = 1'b1;
    exp_rsp  = 8'h00;
    wrr_seen = 1'b0;
  endtask

  // Runs the current cycle, presenting (v,op,a,w) for acceptance at its X3.
  task automatic run_cycle(input bit v, input bit op, input logic [11:0] a,
                           input logic [3:0] w, input int abort_t);
    bit acc = 1'b0;
    wrr_seen = 1'b0;
    for (int t = 0; t < 32; t++) begin
      chk("bus", t, {4'h0, obs}, {4'h0, model(t, cur_kind, cur_addr, cur_wd, poc_exp)});
      if (t == 0 || t == 20) begin
        if (t == 20 && cur_kind == c_FETCH) exp_rsp = rom[cur_addr];
        chk("rsp_data", t, {8'h0, rsp_data}, {8'h0, exp_rsp});
      end
`ifdef MCS4_IOWR_EN
      if (t == 24 && cmrom_pad && data_dir) io_chip = data_out;
      if (t == 16 && cmrom_pad) wrr_seen = 1'b1;
      if (t == 24 && wrr_seen && data_dir && !cmrom_pad) begin
        if (io_chip == 4'd2) io_out = data_out;
        wrr_seen = 1'b0;
      end
`endif
      if (t == 0) begin
        cmd_valid = v;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = w;
      end
      if (cur_kind == c_FETCH && t >= 12 && t < 16)      data_in = rom[cur_addr][7:4];
      else if (cur_kind == c_FETCH && t >= 16 && t < 20) data_in = rom[cur_addr][3:0];
      else                                               data_in = 4'($urandom);
      if (t == abort_t) return;
      if (t == 31) acc = v && !poc_exp && (cur_kind != c_SRC);
      @(posedge sysclk);
      #1;
    end
    poc_exp = 1'b0;
    if (cur_kind == c_SRC) begin
      cur_kind = c_WRR;
    end else if (acc) begin
`ifdef MCS4_IOWR_EN
      cur_kind = op ? c_SRC : c_FETCH;
`else
      cur_kind = c_FETCH;
`endif
      cur_addr = a;
      cur_wd   = w;
    end else begin
      cur_kind = c_NOP;
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    rom[12'h3A5] = 8'hC7;
    cur_addr = 12'd0;
    cur_wd   = 4'd0;
    #3;
    do_reset();

    run_cycle(1'b1, 1'b0, 12'h3A5, 4'h0, -1);   // poc still high: not accepted
    run_cycle(1'b1, 1'b0, 12'h3A5, 4'h0, -1);   // NOP, accepts 3A5
    run_cycle(1'b1, 1'b0, 12'h000, 4'h0, -1);   // fetch 3A5
    chk("fetch_3a5", 0, {8'h0, rsp_data}, 16'h00C7);
    rv0 = rv_count;
    run_cycle(1'b1, 1'b0, 12'hFFF, 4'h0, -1);   // fetch 000
    run_cycle(1'b0, 1'b0, 12'h000, 4'h0, -1);   // fetch FFF
    chk("b2b_pulses", 0, 16'(rv_count - rv0), 16'd2);

`ifdef MCS4_IOWR_EN
    run_cycle(1'b1, 1'b1, 12'h200, 4'h9, -1);
    run_cycle(1'b1, 1'b0, 12'h123, 4'h0, -1);   // SRC: ready must stay low
    rv0 = rv_count;
    run_cycle(1'b0, 1'b0, 12'h000, 4'h0, -1);   // WRR
    chk("io_out", 0, {12'h0, io_out}, 16'h0009);
    chk("wr_no_pulse", 0, 16'(rv_count - rv0), 16'd0);
`else
    run_cycle(1'b1, 1'b1, 12'h1F0, 4'h5, -1);
    rv0 = rv_count;
    run_cycle(1'b0, 1'b0, 12'h000, 4'h0, -1);   // executes as fetch of 1F0
    chk("op_ignored_pulse", 0, 16'(rv_count - rv0), 16'd1);
    chk("op_ignored_data", 0, {8'h0, rsp_data}, {8'h0, rom[12'h1F0]});
`endif
    run_cycle(1'b0, 1'b0, 12'h000, 4'h0, -1);

    for (int n = 0; n < 24; n++) begin
      run_cycle(($urandom % 4) != 0, 1'($urandom), 12'($urandom), 4'($urandom), -1);
    end
    run_cycle(1'b0, 1'b0, 12'h000, 4'h0, -1);
    run_cycle(1'b0, 1'b0, 12'h000, 4'h0, -1);

    run_cycle(1'b1, 1'b0, 12'h5A5, 4'h0, -1);
    rv0 = rv_count;
    run_cycle(1'b0, 1'b0, 12'h000, 4'h0, 13);   // reset during M1
    do_reset();
    chk("abort_no_pulse", 0, 16'(rv_count - rv0), 16'd0);
    run_cycle(1'b1, 1'b0, 12'h777, 4'h0, -1);
    run_cycle(1'b1, 1'b0, 12'h777, 4'h0, -1);
    run_cycle(1'b0, 1'b0, 12'h000, 4'h0, -1);
    run_cycle(1'b0, 1'b0, 12'h000, 4'h0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mcs4_bus_master.md
MCS4_BUS_MASTER -- requirements
Module: mcs4_bus_master

Interface
REQ-001 SHALL have parameter SAMPLE_TICK, default 2'd3, which selects the sysclk tick (0-3) within M1/M2 at which data_in is sampled.
REQ-002 SHALL have port sysclk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port poc_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have ports clk1_pad, clk2_pad, sync_pad and poc_pad, outputs, 1 bit each: MCS-4 bus phase clocks, sync and power-on-clear.
REQ-005 SHALL have port cmrom_pad, output, 1 bit: ROM command line.
REQ-006 SHALL have port data_in, input, 4 bits: data bus sampled from responders.
REQ-007 SHALL have port data_out, output, 4 bits: bus value driven by this block.
REQ-008 SHALL have port data_dir, output, 1 bit: 1 when this block drives the bus.
REQ-009 SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1), cmd_op (input, 1; 0 = fetch, 1 = port write), cmd_addr (input, 12) and cmd_wdata (input, 4).
REQ-010 SHALL have ports rsp_valid (output, 1) and rsp_data (output, 8): the fetched ROM byte.

Function
REQ-011 SHALL run continuously: 8 subcycles A1 A2 A3 M1 M2 X1 X2 X3, each of 4 sysclk ticks, giving a 32-tick instruction cycle.
REQ-012 SHALL assert clk1_pad on tick 0 and clk2_pad on tick 2 of every subcycle, and hold both low otherwise.
REQ-013 SHALL hold sync_pad high for all 4 ticks of X3 only.
REQ-014 SHALL drive cmd_ready high only on tick 3 of X3, and only when no two-cycle operation is pending; a command is accepted when cmd_valid and cmd_ready are both high, and its fields are latched.
REQ-015 SHALL execute an accepted command starting at the next A1; a cycle with no command is a NOP cycle (data_dir=0 and cmrom_pad=0 throughout).
REQ-016 Fetch SHALL drive addr[3:0] in A1, addr[7:4] in A2 and addr[11:8] in A3 with data_dir=1, and assert cmrom_pad for all of A3.
REQ-017 Fetch SHALL set data_dir=0 in M1 and M2, latch data_in into rsp_data[7:4] at SAMPLE_TICK of M1 and into rsp_data[3:0] at SAMPLE_TICK of M2.
REQ-018 Fetch SHALL pulse rsp_valid for exactly 1 sysclk on tick 0 of X1; rsp_data SHALL hold until the next fetch completes.
REQ-019 Port write SHALL take two instruction cycles, and cmd_ready SHALL stay low across the intervening X3.
- Cycle 1 (SRC): drive cmd_addr in A1-A3 with cmrom_pad=0; in X2 drive cmd_addr[11:8] with data_dir=1 and cmrom_pad=1.
- Cycle 2 (WRR): A1-A3 as in cycle 1; in M2 drive 4'b0010 with cmrom_pad=1; in X2 drive cmd_wdata with data_dir=1 and cmrom_pad=0.
- No rsp_valid pulse is produced for a port write.
REQ-020 SHALL hold data_dir=0 and data_out=0 in every subcycle not listed in REQ-016 and REQ-019.
REQ-021 The phase counter SHALL wrap from X3 tick 3 to A1 tick 0 without a gap cycle.

Reset
REQ-022 While poc_n=0, outputs SHALL be:
- clk1_pad=0, clk2_pad=0, sync_pad=0, cmrom_pad=0
- data_dir=0, data_out=0
- cmd_ready=0, rsp_valid=0, rsp_data=0
- poc_pad=1
- phase at A1 tick 0, and any latched or pending command discarded.
REQ-023 After poc_n rises, clocks SHALL start at A1 tick 0, and poc_pad SHALL stay 1 through the first complete instruction cycle, falling at the next A1 tick 0.
REQ-024 cmd_ready SHALL stay 0 until poc_pad=0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no rsp_valid pulse and no further bus drive.

Configuration
REQ-026 Macro MCS4_IOWR_EN:
- Defined: port write (cmd_op=1) is supported per REQ-019.
- Undefined: cmd_op is ignored, every command executes as a fetch, and the SRC/WRR logic is not built.

Verification
REQ-027 After reset release: poc_pad=1 for 32 ticks, then 0; clk1_pad/clk2_pad alternate with period 4 ticks; sync_pad high for 4 of every 32 ticks.
REQ-028 Fetch of 12'h3A5 with a responder returning 8'hC7 -> bus carries 5, A, 3 in A1-A3, cmrom_pad high in A3, rsp_data=8'hC7, one rsp_valid pulse.
REQ-029 Back-to-back fetches 12'h000 then 12'hFFF with cmd_valid held high -> two consecutive cycles with no NOP cycle between, and two rsp_valid pulses.
REQ-030 With MCS4_IOWR_EN defined, port write addr 12'h200 data 4'h9 -> X2 of cycle 1 carries 2 with cmrom_pad=1; M2 of cycle 2 carries 2 with cmrom_pad=1; X2 of cycle 2 carries 9; an i4001 #2 io_out reads 4'h9.
REQ-031 poc_n pulsed low during M1 of a fetch -> no rsp_valid pulse, all outputs at reset values, and a clean restart at A1.
REQ-032 With MCS4_IOWR_EN undefined, cmd_op=1 with addr 12'h1F0 -> a normal fetch of 12'h1F0 and one rsp_valid pulse.
